gate_arbiter: RTL
=================

# gate_arbiter

Sequencer and two-requester arbiter for the 4-bit zero-gating stage in latches-and-flops. The gating rule passes a nibble unchanged when bit 0 is 0 and forces it to 4'b0000 when bit 0 is 1. This block accepts nibbles from two requesters (A, B) over valid/ready, round-robin arbitrates, and runs the winner through the gating rule in a registered stage. It presents the result on a valid/ready output and keeps pass/block statistics.

## Interface
- CNT_W, 8, width of the pass and block statistic counters (≥ 2)
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- a_data  input  4  requester A nibble
- a_valid  input  1  requester A has a nibble
- a_ready  output  1  A accepted this cycle when a_valid & a_ready
- b_data / b_valid / b_ready  same as A, for requester B
- out_data  output  4  gated nibble
- out_valid  output  1  out_data/out_src valid
- out_src  output  1  source of current output: 0 = A, 1 = B
- out_ready  input  1  downstream accepts when out_valid & out_ready
- clr_cnt  input  1  synchronous clear of both counters
- pass_cnt  output  CNT_W  nibbles forwarded unchanged (bit 0 was 0)
- block_cnt  output  CNT_W  nibbles zeroed (bit 0 was 1)
- busy  output  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, GATE, HOLD.
- IDLE:
  - a_ready/b_ready are driven combinationally from the valids: at most one is high, only in IDLE.
  - Only one valid: that requester is granted.
  - Both valid: the requester not served last is granted.
  - last_src resets to B, so A wins the first contention.
  - On a handshake: capture the nibble and source, update last_src, go to GATE.
- GATE:
  - Apply the gating rule to the captured nibble and register it into out_data.
  - Captured bit 0 = 0: pass_cnt increments.
  - Captured bit 0 = 1: out_data = 4'b0000, block_cnt increments.
  - Go to HOLD. out_ready is ignored in GATE.
- HOLD:
  - out_valid = 1; out_data and out_src stay stable.
  - On out_valid & out_ready, go to IDLE.
  - Stalls indefinitely while out_ready = 0.
- Counters saturate at all-ones and do not wrap.
- clr_cnt has priority over an increment in the same cycle: the counter becomes 0 and that event is not counted.
- Reset mid-operation:
  - Next state is IDLE and any in-flight nibble is discarded.
  - Counters return to 0 and last_src returns to B.
- Requesters hold valid/data until accepted. The block does not check for requester protocol violations.

## Timing
- Reset values: a_ready = 0, b_ready = 0 (during the rst cycle), out_valid = 0, out_data = 4'b0000, out_src = 0, pass_cnt = 0, block_cnt = 0, busy = 0, state = IDLE.
- Latency: with the handshake in cycle N, out_valid rises in cycle N+2.
- Throughput: with out_ready held high, one nibble per 3 cycles (IDLE → GATE → HOLD → IDLE).
- The counter update is visible in cycle N+2, the same cycle as out_valid.
- All outputs are registered except a_ready and b_ready, which depend combinationally on state, last_src, a_valid and b_valid.

## Structure
- Package gate_arb_pkg:
  - WORD_W = 4
  - state enum {IDLE, GATE, HOLD}
  - SRC_A = 1'b0, SRC_B = 1'b1
- One combinational sub-module, nibble_gate: 4-bit in, 4-bit out, plus a 1-bit "blocked" flag. It implements the gating rule and is instantiated once in GATE's datapath.
- The FSM, arbiter and counters stay in gate_arbiter.

## Test plan
- Reset, then A sends 4'b1010 with out_ready = 1: out_data = 4'b1010, out_src = 0, out_valid in cycle N+2 for 1 cycle, pass_cnt = 1.
- B sends 4'b0111: out_data = 4'b0000, out_src = 1, block_cnt = 1, pass_cnt unchanged.
- A and B continuously valid, out_ready = 1, 6 transfers: grant order A, B, A, B, A, B. a_ready and b_ready are never high together.
- out_ready = 0 for 5 cycles in HOLD: out_valid, out_data and out_src stay stable, both readies stay 0. out_ready = 1 returns the FSM to IDLE the next cycle.
- CNT_W = 2, 5 blocked nibbles: block_cnt saturates at 3. Then clr_cnt asserted in the same cycle as a GATE increment: block_cnt = 0.
- rst asserted in HOLD: next cycle out_valid = 0, counters = 0. With both valid afterwards, A is granted first.

Source files
------------

// File: rtl/gate_arb_pkg.sv
// Shared types and constants for the zero-gating arbiter slice.
// Imported by the gate datapath and the arbiter top.
package gate_arb_pkg;

  localparam int WORD_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/gate_arbiter_nibble_gate.sv
// Zero-gating rule: a nibble with bit 0 set is forced to zero and flagged as blocked.
// Otherwise the nibble passes through unchanged.
module nibble_gate
  import gate_arb_pkg::*;
(
  input  logic [WORD_W-1:0] data_i,
  output logic [WORD_W-1:0] data_o,
  output logic              blocked_o
);

  // Gating decision
  always_comb begin
    blocked_o = data_i[0];
    if (data_i[0]) begin
      data_o = {WORD_W{1'b0}};
    end else begin
      data_o = data_i;
    end
  end

endmodule

// File: rtl/gate_arbiter.sv
// Two-requester round-robin arbiter feeding a registered zero-gating stage,
// with a valid/ready output and saturating pass/block statistics.
module gate_arbiter
  import gate_arb_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] a_data,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [WORD_W-1:0] b_data,
  input  logic              b_valid,
  output logic              b_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_src,
  input  logic              out_ready,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  block_cnt,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic                last_src_q, last_src_d;
  logic [WORD_W-1:0]   cap_data_q, cap_data_d;
  logic                cap_src_q, cap_src_d;
  logic [WORD_W-1:0]   out_data_q, out_data_d;
  logic                out_src_q, out_src_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    pass_q, pass_d;
  logic [CNT_W-1:0]    block_q, block_d;
  logic                grant_a_s, grant_b_s;
  logic [WORD_W-1:0]   gated_s;
  logic                blocked_s;

  nibble_gate u_gate (
    .data_i    (cap_data_q),
    .data_o    (gated_s),
    .blocked_o (blocked_s)
  );

  // Round-robin grant: on contention the requester not served last wins
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    if ((state_q == IDLE) && !rst) begin
      if (a_valid && b_valid) begin
        if (last_src_q == SRC_B) begin
          grant_a_s = 1'b1;
        end else begin
          grant_b_s = 1'b1;
        end
      end else if (a_valid) begin
        grant_a_s = 1'b1;
      end else if (b_valid) begin
        grant_b_s = 1'b1;
      end else begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
      end
    end else begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
    end
  end

  assign a_ready = grant_a_s;
  assign b_ready = grant_b_s;

  // Next-state and datapath
  always_comb begin
    state_d    = state_q;
    last_src_d = last_src_q;
    cap_data_d = cap_data_q;
    cap_src_d  = cap_src_q;
    out_data_d = out_data_q;
    out_src_d  = out_src_q;
    case (state_q)
      IDLE: begin
        if (grant_a_s) begin
          cap_data_d = a_data;
          cap_src_d  = SRC_A;
          last_src_d = SRC_A;
          state_d    = GATE;
        end else if (grant_b_s) begin
          cap_data_d = b_data;
          cap_src_d  = SRC_B;
          last_src_d = SRC_B;
          state_d    = GATE;
        end else begin
          state_d = IDLE;
        end
      end
      GATE: begin
        out_data_d = gated_s;
        out_src_d  = cap_src_q;
        state_d    = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    out_valid_d = (state_d == HOLD);
    busy_d      = (state_d != IDLE);
  end

  // Saturating statistics; a clear wins over a same-cycle increment
  always_comb begin
    pass_d  = pass_q;
    block_d = block_q;
    if (clr_cnt) begin
      pass_d  = {CNT_W{1'b0}};
      block_d = {CNT_W{1'b0}};
    end else if (state_q == GATE) begin
      if (blocked_s) begin
        block_d = (block_q == CNT_MAX) ? CNT_MAX : (block_q + CNT_ONE);
      end else begin
        pass_d = (pass_q == CNT_MAX) ? CNT_MAX : (pass_q + CNT_ONE);
      end
    end else begin
      pass_d  = pass_q;
      block_d = block_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_src_q  <= SRC_B;
      cap_data_q  <= {WORD_W{1'b0}};
      cap_src_q   <= SRC_A;
      out_data_q  <= {WORD_W{1'b0}};
      out_src_q   <= SRC_A;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      pass_q      <= {CNT_W{1'b0}};
      block_q     <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      last_src_q  <= last_src_d;
      cap_data_q  <= cap_data_d;
      cap_src_q   <= cap_src_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      pass_q      <= pass_d;
      block_q     <= block_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign pass_cnt  = pass_q;
  assign block_cnt = block_q;

endmodule
